// File: rtl/lc3_pkg.sv
// Shared definitions for the LC-3 PC sequencer.
// Contents:
// - FSM state encoding.
// - Opcode constants.
// - PCMUX and ADDR2MUX encodings.
// - Branch-condition helper.
package lc3_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StF0,
    StF1,
    StF2,
    StDec,
    StBr,
    StJmp,
    StJsr0,
    StJsr1,
    StT0,
    StT1,
    StT2,
    StT3,
    StEx,
    StExw
  } state_e;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  localparam logic [1:0] PCMUX_INC   = 2'b00;
  localparam logic [1:0] PCMUX_BUS   = 2'b01;
  localparam logic [1:0] PCMUX_ADDER = 2'b10;
  localparam logic [1:0] PCMUX_HOLD  = 2'b11;

  localparam logic [1:0] ADDR2_ZERO  = 2'b00;
  localparam logic [1:0] ADDR2_OFF9  = 2'b01;
  localparam logic [1:0] ADDR2_OFF11 = 2'b10;

  // A branch is taken when any requested condition code is currently set.
  function automatic logic br_taken(logic [2:0] nzp_req, logic n, logic z, logic p);
    return (nzp_req[2] & n) | (nzp_req[1] & z) | (nzp_req[0] & p);
  endfunction

endpackage

// File: rtl/lc3_pc_sequencer_if.sv
// Bus between the PC sequencer and the LC-3 datapath and memory.
// Signal groups:
// - Status into the sequencer: run, ir, n/z/p, mem_ready, exec_done.
// - Controls out of the sequencer: exec_start, PC/MAR/MDR/IR/regfile controls, mem_err.
// Modports:
// - master: the sequencer side.
// - slave: the datapath side.
interface lc3_pc_sequencer_if;
  logic        run;
  logic [15:0] ir;
  logic        n;
  logic        z;
  logic        p;
  logic        mem_ready;
  logic        exec_done;

  logic        exec_start;
  logic        LDPC;
  logic [1:0]  PCMUX;
  logic        GatePC;
  logic        LDMAR;
  logic        LDMDR;
  logic        LDIR;
  logic        GateMDR;
  logic        MIO_EN;
  logic        GateMARMUX;
  logic        MARMUX;
  logic        ADDR1MUX;
  logic [1:0]  ADDR2MUX;
  logic        LDREG;
  logic        DR_R7;
  logic        mem_err;

  modport master (
    input  run, ir, n, z, p, mem_ready, exec_done,
    output exec_start, LDPC, PCMUX, GatePC, LDMAR, LDMDR, LDIR, GateMDR, MIO_EN,
           GateMARMUX, MARMUX, ADDR1MUX, ADDR2MUX, LDREG, DR_R7, mem_err
  );

  modport slave (
    output run, ir, n, z, p, mem_ready, exec_done,
    input  exec_start, LDPC, PCMUX, GatePC, LDMAR, LDMDR, LDIR, GateMDR, MIO_EN,
           GateMARMUX, MARMUX, ADDR1MUX, ADDR2MUX, LDREG, DR_R7, mem_err
  );
endinterface

// File: rtl/lc3_mem_wait_timer.sv
// Memory wait timer shared by the fetch (F1) and TRAP-vector (T2) wait states.
// Ports:
// - clk, reset: clock and synchronous active-high reset.
// - clear: zero the count (asserted whenever not waiting).
// - tick: one more cycle spent waiting without mem_ready.
// - expired: this tick is the MEM_TIMEOUT-th consecutive wait cycle.
module lc3_mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int unsigned W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(MEM_TIMEOUT - 1);

  logic [W-1:0] cnt_q;

  // Expiry is flagged on the tick that would bring the count up to MEM_TIMEOUT.
  assign expired = tick && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (tick && !expired) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/lc3_pc_sequencer.sv
// Moore control FSM for the LC-3 PC, MAR, MDR, IR and R7-write paths.
// Sequences:
// - Instruction fetch.
// - BR, JMP/RET, JSR/JSRR, TRAP.
// - Any other opcode is handed to the execute unit via exec_start/exec_done.
// Ports:
// - clk, reset: clock and synchronous active-high reset.
// - bus: lc3_pc_sequencer_if.master (status in, datapath controls out).
module lc3_pc_sequencer
  import lc3_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input logic                  clk,
  input logic                  reset,
  lc3_pc_sequencer_if.master   bus
);

  state_e state_q, state_d;
  logic   mem_err_q, mem_err_d;
  logic   waiting;
  logic   tick;
  logic   expired;

  assign waiting = (state_q == StF1) || (state_q == StT2);
  assign tick    = waiting && !bus.mem_ready;

  lc3_mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (!waiting),
    .tick    (tick),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_err_q <= mem_err_d;
    end
  end

  // Next state
  always_comb begin
    state_d   = state_q;
    mem_err_d = mem_err_q;
    unique case (state_q)
      StIdle: if (bus.run) state_d = StF0;
      StF0:   state_d = StF1;
      StF1: begin
        if (bus.mem_ready) begin
          state_d = StF2;
        end else if (expired) begin
          state_d   = StIdle;
          mem_err_d = 1'b1;
        end
      end
      StF2:   state_d = StDec;
      StDec: begin
        unique case (bus.ir[15:12])
          OP_BR:   state_d = StBr;
          OP_JMP:  state_d = StJmp;
          OP_JSR:  state_d = StJsr0;
          OP_TRAP: state_d = StT0;
          default: state_d = StEx;
        endcase
      end
      StBr:   state_d = StF0;
      StJmp:  state_d = StF0;
      StJsr0: state_d = StJsr1;
      StJsr1: state_d = StF0;
      StT0:   state_d = StT1;
      StT1:   state_d = StT2;
      StT2: begin
        if (bus.mem_ready) begin
          state_d = StT3;
        end else if (expired) begin
          state_d   = StIdle;
          mem_err_d = 1'b1;
        end
      end
      StT3:   state_d = StF0;
      StEx:   state_d = StExw;
      // exec_done is only looked at here, so a done seen during StEx is ignored.
      StExw:  if (bus.exec_done) state_d = StF0;
      default: state_d = StIdle;
    endcase
  end

  // Outputs: forced to the idle pattern while reset is asserted so nothing
  // (in particular exec_start) escapes in the reset cycle.
  always_comb begin
    bus.exec_start = 1'b0;
    bus.LDPC       = 1'b0;
    bus.PCMUX      = PCMUX_HOLD;
    bus.GatePC     = 1'b0;
    bus.LDMAR      = 1'b0;
    bus.LDMDR      = 1'b0;
    bus.LDIR       = 1'b0;
    bus.GateMDR    = 1'b0;
    bus.MIO_EN     = 1'b0;
    bus.GateMARMUX = 1'b0;
    bus.MARMUX     = 1'b0;
    bus.ADDR1MUX   = 1'b0;
    bus.ADDR2MUX   = ADDR2_ZERO;
    bus.LDREG      = 1'b0;
    bus.DR_R7      = 1'b0;
    bus.mem_err    = mem_err_q && !reset;
    if (!reset) begin
      unique case (state_q)
        StF0: begin
          bus.GatePC = 1'b1;
          bus.LDMAR  = 1'b1;
          bus.LDPC   = 1'b1;
          bus.PCMUX  = PCMUX_INC;
        end
        StF1, StT2: begin
          bus.MIO_EN = 1'b1;
          bus.LDMDR  = bus.mem_ready;
        end
        StF2: begin
          bus.GateMDR = 1'b1;
          bus.LDIR    = 1'b1;
        end
        StBr: begin
          if (br_taken(bus.ir[11:9], bus.n, bus.z, bus.p)) begin
            bus.LDPC     = 1'b1;
            bus.PCMUX    = PCMUX_ADDER;
            bus.ADDR1MUX = 1'b0;
            bus.ADDR2MUX = ADDR2_OFF9;
          end
        end
        StJmp: begin
          bus.LDPC     = 1'b1;
          bus.PCMUX    = PCMUX_ADDER;
          bus.ADDR1MUX = 1'b1;
          bus.ADDR2MUX = ADDR2_ZERO;
        end
        StJsr0, StT1: begin
          bus.GatePC = 1'b1;
          bus.LDREG  = 1'b1;
          bus.DR_R7  = 1'b1;
        end
        StJsr1: begin
          bus.LDPC  = 1'b1;
          bus.PCMUX = PCMUX_ADDER;
          // JSRR R7 reads R7 after StJsr0 wrote it, so it jumps to the return address.
          if (bus.ir[11]) begin
            bus.ADDR1MUX = 1'b0;
            bus.ADDR2MUX = ADDR2_OFF11;
          end else begin
            bus.ADDR1MUX = 1'b1;
            bus.ADDR2MUX = ADDR2_ZERO;
          end
        end
        StT0: begin
          bus.GateMARMUX = 1'b1;
          bus.MARMUX     = 1'b1;
          bus.LDMAR      = 1'b1;
        end
        StT3: begin
          bus.GateMDR = 1'b1;
          bus.LDPC    = 1'b1;
          bus.PCMUX   = PCMUX_BUS;
        end
        StEx: bus.exec_start = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_pc_sequencer.sv
// Self-checking bench for lc3_pc_sequencer (MEM_TIMEOUT = 4).
// Table-driven instruction sequences followed by hand-written corner cases.
module tb_lc3_pc_sequencer;

  typedef struct packed {
    logic       exec_start;
    logic       ldpc;
    logic [1:0] pcmux;
    logic       gatepc;
    logic       ldmar;
    logic       ldmdr;
    logic       ldir;
    logic       gatemdr;
    logic       mio_en;
    logic       gatemarmux;
    logic       marmux;
    logic       addr1mux;
    logic [1:0] addr2mux;
    logic       ldreg;
    logic       dr_r7;
    logic       mem_err;
  } ctl_t;

  localparam ctl_t C_IDLE = '{pcmux: 2'b11, default: '0};
  localparam ctl_t C_IDLE_E = '{pcmux: 2'b11, mem_err: 1'b1, default: '0};
  localparam ctl_t C_F0 = '{gatepc: 1'b1, ldmar: 1'b1, ldpc: 1'b1, pcmux: 2'b00, default: '0};
  localparam ctl_t C_F0E = '{gatepc: 1'b1, ldmar: 1'b1, ldpc: 1'b1, pcmux: 2'b00,
                             mem_err: 1'b1, default: '0};
  localparam ctl_t C_F1W = '{mio_en: 1'b1, pcmux: 2'b11, default: '0};
  localparam ctl_t C_F1WE = '{mio_en: 1'b1, pcmux: 2'b11, mem_err: 1'b1, default: '0};
  localparam ctl_t C_F1R = '{mio_en: 1'b1, ldmdr: 1'b1, pcmux: 2'b11, default: '0};
  localparam ctl_t C_F2 = '{gatemdr: 1'b1, ldir: 1'b1, pcmux: 2'b11, default: '0};
  localparam ctl_t C_BRT = '{ldpc: 1'b1, pcmux: 2'b10, addr2mux: 2'b01, default: '0};
  localparam ctl_t C_JMP = '{ldpc: 1'b1, pcmux: 2'b10, addr1mux: 1'b1, default: '0};
  localparam ctl_t C_R7 = '{gatepc: 1'b1, ldreg: 1'b1, dr_r7: 1'b1, pcmux: 2'b11, default: '0};
  localparam ctl_t C_JSR = '{ldpc: 1'b1, pcmux: 2'b10, addr2mux: 2'b10, default: '0};
  localparam ctl_t C_T0 = '{gatemarmux: 1'b1, marmux: 1'b1, ldmar: 1'b1, pcmux: 2'b11,
                            default: '0};
  localparam ctl_t C_T3 = '{gatemdr: 1'b1, ldpc: 1'b1, pcmux: 2'b01, default: '0};
  localparam ctl_t C_EX = '{exec_start: 1'b1, pcmux: 2'b11, default: '0};

  typedef struct {
    logic [15:0]      ir;
    logic             n;
    logic             z;
    logic             p;
    int               tlen;
    ctl_t [0:5]       tail;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   failed = 0;
  ctl_t act;
  vec_t vecs [10];
  ctl_t prefix [4];

  lc3_pc_sequencer_if bus ();

  lc3_pc_sequencer #(
    .MEM_TIMEOUT (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always_comb begin
    act.exec_start = bus.exec_start;
    act.ldpc       = bus.LDPC;
    act.pcmux      = bus.PCMUX;
    act.gatepc     = bus.GatePC;
    act.ldmar      = bus.LDMAR;
    act.ldmdr      = bus.LDMDR;
    act.ldir       = bus.LDIR;
    act.gatemdr    = bus.GateMDR;
    act.mio_en     = bus.MIO_EN;
    act.gatemarmux = bus.GateMARMUX;
    act.marmux     = bus.MARMUX;
    act.addr1mux   = bus.ADDR1MUX;
    act.addr2mux   = bus.ADDR2MUX;
    act.ldreg      = bus.LDREG;
    act.dr_r7      = bus.DR_R7;
    act.mem_err    = bus.mem_err;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input ctl_t exp, input string name);
    #1;
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: controls got %h expected %h", name, act, exp);
    end
  endtask

  // Runs a fetch from StF0 through DEC, leaving the FSM in the cycle after DEC.
  task automatic fetch_to_dec(input string tag);
    chk(C_F0, {tag, "_f0"});
    step();
    chk(C_F1R, {tag, "_f1"});
    step();
    chk(C_F2, {tag, "_f2"});
    step();
    chk(C_IDLE, {tag, "_dec"});
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    prefix[0] = C_F0;
    prefix[1] = C_F1R;
    prefix[2] = C_F2;
    prefix[3] = C_IDLE;
    vecs[0] = '{ir: 16'h1021, n: 0, z: 0, p: 0, tlen: 3,
                tail: {C_EX, C_IDLE, C_F0, C_IDLE, C_IDLE, C_IDLE}};
    vecs[1] = '{ir: 16'h0E05, n: 0, z: 1, p: 0, tlen: 2,
                tail: {C_BRT, C_F0, C_IDLE, C_IDLE, C_IDLE, C_IDLE}};
    vecs[2] = '{ir: 16'h0805, n: 0, z: 1, p: 0, tlen: 2,
                tail: {C_IDLE, C_F0, C_IDLE, C_IDLE, C_IDLE, C_IDLE}};
    vecs[3] = '{ir: 16'h0205, n: 0, z: 0, p: 1, tlen: 2,
                tail: {C_BRT, C_F0, C_IDLE, C_IDLE, C_IDLE, C_IDLE}};
    vecs[4] = '{ir: 16'h0005, n: 1, z: 1, p: 1, tlen: 2,
                tail: {C_IDLE, C_F0, C_IDLE, C_IDLE, C_IDLE, C_IDLE}};
    vecs[5] = '{ir: 16'hC1C0, n: 0, z: 0, p: 0, tlen: 2,
                tail: {C_JMP, C_F0, C_IDLE, C_IDLE, C_IDLE, C_IDLE}};
    vecs[6] = '{ir: 16'h4803, n: 0, z: 0, p: 0, tlen: 3,
                tail: {C_R7, C_JSR, C_F0, C_IDLE, C_IDLE, C_IDLE}};
    vecs[7] = '{ir: 16'h4080, n: 0, z: 0, p: 0, tlen: 3,
                tail: {C_R7, C_JMP, C_F0, C_IDLE, C_IDLE, C_IDLE}};
    vecs[8] = '{ir: 16'hF025, n: 0, z: 0, p: 0, tlen: 5,
                tail: {C_T0, C_R7, C_F1R, C_T3, C_F0, C_IDLE}};
    vecs[9] = '{ir: 16'h7000, n: 0, z: 0, p: 0, tlen: 3,
                tail: {C_EX, C_IDLE, C_F0, C_IDLE, C_IDLE, C_IDLE}};

    reset = 1'b1;
    bus.run = 1'b0;
    bus.ir = 16'h1021;
    bus.n = 1'b0;
    bus.z = 1'b0;
    bus.p = 1'b0;
    bus.mem_ready = 1'b0;
    bus.exec_done = 1'b0;
    step();
    step();
    chk(C_IDLE, "reset_state");
    reset = 1'b0;
    chk(C_IDLE, "idle_after_reset");
    step();
    chk(C_IDLE, "idle_without_run");
    bus.run = 1'b1;
    step();

    // Table: each instruction from F0 through its own path back to F0.
    for (int v = 0; v < 10; v++) begin
      bus.ir = vecs[v].ir;
      bus.n = vecs[v].n;
      bus.z = vecs[v].z;
      bus.p = vecs[v].p;
      bus.mem_ready = 1'b1;
      bus.exec_done = 1'b1;
      for (int k = 0; k < 4; k++) begin
        chk(prefix[k], $sformatf("vec%0d_fetch%0d", v, k));
        step();
      end
      for (int k = 0; k < vecs[v].tlen; k++) begin
        chk(vecs[v].tail[k], $sformatf("vec%0d_ir%h_cyc%0d", v, vecs[v].ir, k));
        if (k < vecs[v].tlen - 1) step();
      end
    end

    // exec_start lands 4 cycles after F0; done during EX ignored; EXW holds.
    bus.run = 1'b0;
    bus.ir = 16'h1021;
    bus.exec_done = 1'b0;
    fetch_to_dec("exw");
    chk(C_EX, "exw_ex_pulse");
    bus.exec_done = 1'b1;
    step();
    bus.exec_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk(C_IDLE, $sformatf("exw_hold%0d", i));
      step();
    end
    bus.exec_done = 1'b1;
    chk(C_IDLE, "exw_done");
    step();
    bus.exec_done = 1'b0;

    // TRAP with three wait cycles in T2.
    bus.ir = 16'hF025;
    fetch_to_dec("trap");
    chk(C_T0, "trap_t0");
    step();
    bus.mem_ready = 1'b0;
    chk(C_R7, "trap_t1");
    step();
    for (int i = 0; i < 3; i++) begin
      chk(C_F1W, $sformatf("trap_t2_wait%0d", i));
      step();
    end
    bus.mem_ready = 1'b1;
    chk(C_F1R, "trap_t2_ready");
    step();
    chk(C_T3, "trap_t3");
    step();

    // Reset asserted in the EX cycle must suppress exec_start.
    bus.ir = 16'h1021;
    fetch_to_dec("rst_ex");
    reset = 1'b1;
    chk(C_IDLE, "reset_in_ex");
    step();
    reset = 1'b0;
    chk(C_IDLE, "idle_after_ex_reset");
    bus.run = 1'b1;
    step();

    // Fetch timeout: four wait cycles, then IDLE with sticky mem_err.
    bus.mem_ready = 1'b0;
    chk(C_F0, "to_f0");
    step();
    bus.run = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk(C_F1W, $sformatf("to_wait%0d", i));
      step();
    end
    chk(C_IDLE_E, "to_idle_err");
    step();
    chk(C_IDLE_E, "to_err_sticky");
    bus.run = 1'b1;
    step();
    chk(C_F0E, "to_rerun_f0");
    step();
    chk(C_F1WE, "to_rerun_f1a");
    step();
    chk(C_F1WE, "to_rerun_f1b");
    reset = 1'b1;
    chk(C_IDLE, "reset_in_f1");
    step();
    reset = 1'b0;
    bus.run = 1'b0;
    chk(C_IDLE, "idle_after_f1_reset");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/lc3_pc_sequencer.md
Name: lc3_pc_sequencer

Overview:
- Moore control FSM that sequences the LC-3 program counter block and its supporting registers (MAR, MDR, IR, R7 write).
- Handles instruction fetch and all PC-redirecting opcodes: BR, JMP/RET, JSR/JSRR, TRAP.
- Every other opcode goes to the execute unit over a start/done handshake.
- Sits between the memory interface, the IR/NZP registers and the datapath control lines of the PC, MAR, MDR and register-file blocks.

Parameters:
- MEM_TIMEOUT, 255, maximum cycles spent waiting on mem_ready before abort; width of the wait counter is $clog2(MEM_TIMEOUT+1).

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- run  input  1  allows leaving IDLE; sampled only in IDLE
- ir  input  16  current instruction register contents
- n, z, p  input  1 each  condition-code flags
- mem_ready  input  1  memory read data valid in the MDR-load cycle
- exec_done  input  1  execute unit finished the current instruction
- exec_start  output  1  one-cycle pulse handing the instruction to the execute unit
- LDPC  output  1  PC load enable
- PCMUX  output  2  00 = PC+1, 01 = bus, 10 = address adder, 11 = hold
- GatePC  output  1  drive PC onto the bus
- LDMAR, LDMDR, LDIR, GateMDR  output  1 each  memory path controls
- MIO_EN  output  1  memory access enable
- GateMARMUX, MARMUX  output  1 each  MARMUX 1 = ZEXT(ir[7:0]), 0 = adder
- ADDR1MUX  output  1  0 = PC, 1 = BaseR (ir[8:6])
- ADDR2MUX  output  2  00 = zero, 01 = SEXT off9, 10 = SEXT off11
- LDREG, DR_R7  output  1 each  register write; DR_R7 forces destination R7
- mem_err  output  1  sticky memory-timeout flag

Behaviour:
- Reset (synchronous, active-high): state := IDLE, wait counter := 0, mem_err := 0.
  - All outputs 0 except PCMUX = 11.
  - Reset wins over every other input in the same cycle, including mid-fetch or mid-execute. exec_start is never asserted in the reset cycle.
- Outputs are decoded purely from state and, in BR/JSR states, from ir and nzp. Unlisted outputs are 0 and PCMUX = 11.
- States and transitions:
  - IDLE: no controls. Goes to F0 when run = 1.
  - F0: GatePC, LDMAR, LDPC, PCMUX = 00, so MAR <- PC and PC <- PC+1 in one cycle. Goes to F1.
  - F1: MIO_EN held; LDMDR = mem_ready.
    - mem_ready = 1: go to F2.
    - Otherwise the wait counter increments. When it reaches MEM_TIMEOUT, set mem_err and go to IDLE.
  - F2: GateMDR, LDIR. Goes to DEC. The wait counter clears on every entry to F1 or T2.
  - DEC: no controls; branch on ir[15:12].
    - 0000 goes to BR, 1100 to JMP, 0100 to JSR0, 1111 to T0.
    - All other opcodes go to EX.
  - BR: taken = (ir[11]&n)|(ir[10]&z)|(ir[9]&p).
    - If taken: LDPC, PCMUX = 10, ADDR1MUX = 0, ADDR2MUX = 01.
    - Goes to F0. nzp = 000 or a not-taken branch costs the cycle with no PC change.
  - JMP: LDPC, PCMUX = 10, ADDR1MUX = 1, ADDR2MUX = 00. Goes to F0.
  - JSR0: GatePC, LDREG, DR_R7 (R7 <- incremented PC). Goes to JSR1.
  - JSR1: LDPC, PCMUX = 10.
    - ir[11] = 1 (JSR): ADDR1MUX = 0, ADDR2MUX = 10.
    - ir[11] = 0 (JSRR): ADDR1MUX = 1, ADDR2MUX = 00. JSRR R7 jumps to the new R7 (the return address); this is the defined behaviour.
    - Goes to F0.
  - T0: GateMARMUX, MARMUX = 1, LDMAR. Goes to T1.
  - T1: GatePC, LDREG, DR_R7. Goes to T2.
  - T2: same as F1 (same timeout rule). Goes to T3 on mem_ready.
  - T3: GateMDR, LDPC, PCMUX = 01. Goes to F0.
  - EX: exec_start = 1 for exactly the entry cycle. Then goes to EXW.
  - EXW: waits for exec_done. exec_done in the EX cycle itself is ignored. On exec_done, goes to F0.
- run is ignored outside IDLE. The sequencer runs until reset or a memory timeout.
- Latency:
  - Fetch is 3 cycles with a zero-wait memory; BR/JMP add 2 cycles (DEC plus one).
  - JSR adds 3 cycles; TRAP adds 5 cycles plus memory wait.
- mem_err stays set until reset. A subsequent run restarts at F0 with the PC unchanged.

Decomposition:
- Shared package lc3_pkg: state enum, opcode constants (OP_BR, OP_JMP, OP_JSR, OP_TRAP), PCMUX/ADDR2MUX encodings.
- One sub-module is natural: lc3_mem_wait_timer (counter, clear, expiry compare, MEM_TIMEOUT parameter), instantiated once and shared by F1/T2.

Test Plan:
- Reset, then run = 1, zero-wait memory, PC = 0x3000, ir = 0x1021 (ADD):
  - F0 shows GatePC/LDMAR/LDPC with PCMUX = 00.
  - exec_start pulses once, 4 cycles after F0.
  - Holding exec_done = 0 for 10 cycles keeps the FSM in EXW.
- ir = 0x0E05 (BRnzp), flags z = 1 -> BR cycle has LDPC = 1, PCMUX = 10, ADDR2MUX = 01.
- ir = 0x0805 (BRn), z = 1 -> BR cycle has LDPC = 0, next state F0.
- ir = 0x4803 (JSR):
  - JSR0 has LDREG = 1 and DR_R7 = 1.
  - JSR1 has ADDR1MUX = 0, ADDR2MUX = 10.
  - Then F0.
- ir = 0xF025 (TRAP x25), mem_ready delayed 3 cycles in T2:
  - T0 has MARMUX = 1, then T1 writes R7.
  - T3 has PCMUX = 01 with LDPC = 1.
- MEM_TIMEOUT = 4, mem_ready held 0 in F1 -> mem_err rises after 4 wait cycles, state returns to IDLE. Asserting reset during F1 clears mem_err and yields all-idle outputs on the next edge.
